// File: rtl/core_data_tcdm_bridge.sv
// ----------------------------------------------------------------------------
// core_data_tcdm_bridge
//
// Purpose: bridges a core data port onto an HCI/TCDM master port. Requests
// inside the TCDM window with no atomic operation are passed straight through
// combinationally. Anything else is answered locally with an error response
// one cycle after it is granted. In-flight TCDM transactions are counted so
// that the core never has more than MAX_OUTST of them outstanding.
//
// Configuration macro: BRIDGE_MISALIGN_CHK_EN
//   defined   -> addresses with addr[1:0] != 0 are treated as illegal
//   undefined -> misaligned window addresses go to TCDM word-aligned
//
// Ports:
//   clk_i, rst_i                    clock, asynchronous active-high reset
//   core_req_i .. core_atop_i       core data request
//   core_gnt_o .. core_exokay_o     core data grant / response
//   tcdm_req_o .. tcdm_data_o       TCDM request (tcdm_wen_o = 1 means read)
//   tcdm_gnt_i, tcdm_r_valid_i,
//   tcdm_r_data_i                   TCDM grant / response
// ----------------------------------------------------------------------------
module core_data_tcdm_bridge #(
  parameter int unsigned         ADDR_W    = 32,
  parameter int unsigned         DATA_W    = 32,
  parameter int unsigned         MAX_OUTST = 2,
  parameter logic [ADDR_W-1:0]   TCDM_BASE = 32'h0000_0000,
  parameter logic [ADDR_W-1:0]   TCDM_SIZE = 32'h0010_0000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  // core data request
  input  logic                  core_req_i,
  input  logic [ADDR_W-1:0]     core_addr_i,
  input  logic                  core_we_i,
  input  logic [DATA_W/8-1:0]   core_be_i,
  input  logic [DATA_W-1:0]     core_wdata_i,
  input  logic [5:0]            core_atop_i,
  // core data response
  output logic                  core_gnt_o,
  output logic                  core_rvalid_o,
  output logic [DATA_W-1:0]     core_rdata_o,
  output logic                  core_err_o,
  output logic                  core_exokay_o,
  // TCDM master port
  output logic                  tcdm_req_o,
  input  logic                  tcdm_gnt_i,
  output logic [ADDR_W-1:0]     tcdm_add_o,
  output logic                  tcdm_wen_o,
  output logic [DATA_W/8-1:0]   tcdm_be_o,
  output logic [DATA_W-1:0]     tcdm_data_o,
  input  logic                  tcdm_r_valid_i,
  input  logic [DATA_W-1:0]     tcdm_r_data_i
);

  localparam int unsigned        CNT_W   = $clog2(MAX_OUTST + 1);
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(MAX_OUTST);
  localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0]   CNT_ZERO = {CNT_W{1'b0}};

  logic [CNT_W-1:0]   cnt_r;
  logic               err_pend_r;

  logic [ADDR_W:0]    off_s;
  logic               in_win_s;
  logic               aligned_s;
  logic [ADDR_W-1:0]  add_s;
  logic               legal_s;
  logic               idle_s;
  logic               slot_free_s;
  logic               tcdm_req_s;
  logic               ill_gnt_s;
  logic               hs_s;
  logic               rsp_s;

  // Address window / alignment classification of the current request.
  always_comb begin
    // one extra bit catches addresses below the base (borrow out of the subtract)
    off_s    = {1'b0, core_addr_i} - {1'b0, TCDM_BASE};
    in_win_s = ~off_s[ADDR_W] & (off_s[ADDR_W-1:0] < TCDM_SIZE);
`ifdef BRIDGE_MISALIGN_CHK_EN
    aligned_s = (core_addr_i[1:0] == 2'b00);
    add_s     = core_addr_i;
`else
    aligned_s = 1'b1;
    add_s     = {core_addr_i[ADDR_W-1:2], 2'b00};
`endif
    legal_s  = in_win_s & (core_atop_i == 6'd0) & aligned_s;
  end

  // Request steering, grant generation and response muxing.
  always_comb begin
    idle_s      = (cnt_r == CNT_ZERO);
    slot_free_s = (cnt_r < CNT_MAX);
    // reset gating keeps the request-driven outputs low while rst_i is high
    tcdm_req_s  = ~rst_i & core_req_i & legal_s & slot_free_s & ~err_pend_r;
    // an illegal request waits until everything in flight has drained so its
    // error response cannot overtake an earlier TCDM response
    ill_gnt_s   = ~rst_i & core_req_i & ~legal_s & idle_s & ~err_pend_r;
    hs_s        = tcdm_req_s & tcdm_gnt_i;
    // stray TCDM responses with nothing outstanding are dropped
    rsp_s       = tcdm_r_valid_i & ~idle_s;

    tcdm_req_o    = tcdm_req_s;
    tcdm_add_o    = add_s;
    tcdm_wen_o    = ~core_we_i;
    tcdm_be_o     = core_be_i;
    tcdm_data_o   = core_wdata_i;

    core_gnt_o    = hs_s | ill_gnt_s;
    core_rvalid_o = rsp_s | err_pend_r;
    core_err_o    = err_pend_r;
    core_exokay_o = 1'b0;
    if (rsp_s && !err_pend_r) begin
      core_rdata_o = tcdm_r_data_i;
    end else begin
      core_rdata_o = {DATA_W{1'b0}};
    end
  end

  // Outstanding TCDM transaction counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_r <= CNT_ZERO;
    end else begin
      case ({hs_s, rsp_s})
        2'b10:   cnt_r <= cnt_r + CNT_ONE;
        2'b01:   cnt_r <= cnt_r - CNT_ONE;
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Local error response, issued the cycle after an illegal grant.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_pend_r <= 1'b0;
    end else begin
      err_pend_r <= ill_gnt_s;
    end
  end

endmodule

// File: tb/tb_core_data_tcdm_bridge.sv
// ----------------------------------------------------------------------------
// tb_core_data_tcdm_bridge
//
// Directed bench for core_data_tcdm_bridge with default parameters
// (MAX_OUTST = 2, window 0x0000_0000 .. 0x000F_FFFF). Inputs change on the
// falling edge; outputs are sampled 1 ns later, well away from the rising edge.
// ----------------------------------------------------------------------------
module tb_core_data_tcdm_bridge;

  logic        clk;
  logic        rst;
  logic        core_req;
  logic [31:0] core_addr;
  logic        core_we;
  logic [3:0]  core_be;
  logic [31:0] core_wdata;
  logic [5:0]  core_atop;
  logic        core_gnt;
  logic        core_rvalid;
  logic [31:0] core_rdata;
  logic        core_err;
  logic        core_exokay;
  logic        tcdm_req;
  logic        tcdm_gnt;
  logic [31:0] tcdm_add;
  logic        tcdm_wen;
  logic [3:0]  tcdm_be;
  logic [31:0] tcdm_data;
  logic        tcdm_r_valid;
  logic [31:0] tcdm_r_data;

  int n_cmp  = 0;
  int n_fail = 0;

  core_data_tcdm_bridge dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .core_req_i     (core_req),
    .core_addr_i    (core_addr),
    .core_we_i      (core_we),
    .core_be_i      (core_be),
    .core_wdata_i   (core_wdata),
    .core_atop_i    (core_atop),
    .core_gnt_o     (core_gnt),
    .core_rvalid_o  (core_rvalid),
    .core_rdata_o   (core_rdata),
    .core_err_o     (core_err),
    .core_exokay_o  (core_exokay),
    .tcdm_req_o     (tcdm_req),
    .tcdm_gnt_i     (tcdm_gnt),
    .tcdm_add_o     (tcdm_add),
    .tcdm_wen_o     (tcdm_wen),
    .tcdm_be_o      (tcdm_be),
    .tcdm_data_o    (tcdm_data),
    .tcdm_r_valid_i (tcdm_r_valid),
    .tcdm_r_data_i  (tcdm_r_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle worth of inputs at the falling edge, then settle 1 ns.
  task automatic step(input logic req, input logic [31:0] addr, input logic we,
                      input logic [5:0] atop, input logic gnt,
                      input logic rv, input logic [31:0] rdata);
    @(negedge clk);
    core_req     = req;
    core_addr    = addr;
    core_we      = we;
    core_atop    = atop;
    tcdm_gnt     = gnt;
    tcdm_r_valid = rv;
    tcdm_r_data  = rdata;
    #1;
  endtask

  // Core-side response check: rvalid, err, rdata.
  task automatic chk_rsp(input string tag, input logic v, input logic e, input logic [31:0] d);
    chk({tag, "_rvalid"}, {31'd0, core_rvalid}, {31'd0, v});
    chk({tag, "_err"},    {31'd0, core_err},    {31'd0, e});
    chk({tag, "_rdata"},  core_rdata,           d);
  endtask

  // Request-side check: core grant and TCDM request.
  task automatic chk_req(input string tag, input logic g, input logic r);
    chk({tag, "_gnt"},  {31'd0, core_gnt}, {31'd0, g});
    chk({tag, "_treq"}, {31'd0, tcdm_req}, {31'd0, r});
  endtask

  initial begin
    rst          = 1'b1;
    core_req     = 1'b1;
    core_addr    = 32'h0000_0100;
    core_we      = 1'b0;
    core_be      = 4'hF;
    core_wdata   = 32'h0;
    core_atop    = 6'd0;
    tcdm_gnt     = 1'b1;
    tcdm_r_valid = 1'b1;
    tcdm_r_data  = 32'hFFFF_FFFF;
    #2;
    // reset: all outputs low even with a request and a response on the inputs
    chk_req("rst", 1'b0, 1'b0);
    chk_rsp("rst", 1'b0, 1'b0, 32'h0);
    chk("rst_exokay", {31'd0, core_exokay}, 32'd0);

    step(1'b0, 32'h0, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0);
    rst = 1'b0;
    #1;

    // single read at 0x100, granted same cycle, data next cycle
    step(1'b1, 32'h0000_0100, 1'b0, 6'd0, 1'b1, 1'b0, 32'h0);
    chk_req("rd", 1'b1, 1'b1);
    chk("rd_add", tcdm_add, 32'h0000_0100);
    chk("rd_wen", {31'd0, tcdm_wen}, 32'd1);
    step(1'b0, 32'h0, 1'b0, 6'd0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    chk_rsp("rd_rsp", 1'b1, 1'b0, 32'hDEAD_BEEF);
    step(1'b0, 32'h0, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0);
    chk_rsp("rd_idle", 1'b0, 1'b0, 32'h0);

    // write with TCDM grant delayed one cycle
    core_wdata = 32'h1234_5678;
    core_be    = 4'h3;
    step(1'b1, 32'h0000_0200, 1'b1, 6'd0, 1'b0, 1'b0, 32'h0);
    chk_req("wr_wait", 1'b0, 1'b1);
    chk("wr_wen", {31'd0, tcdm_wen}, 32'd0);
    chk("wr_data", tcdm_data, 32'h1234_5678);
    chk("wr_be", {28'd0, tcdm_be}, 32'h3);
    step(1'b1, 32'h0000_0200, 1'b1, 6'd0, 1'b1, 1'b0, 32'h0);
    chk_req("wr_gnt", 1'b1, 1'b1);
    core_be = 4'hF;
    step(1'b0, 32'h0, 1'b0, 6'd0, 1'b0, 1'b1, 32'h0);
    chk_rsp("wr_rsp", 1'b1, 1'b0, 32'h0);

    // three back-to-back reads with MAX_OUTST = 2
    step(1'b1, 32'h0000_0010, 1'b0, 6'd0, 1'b1, 1'b0, 32'h0);
    chk_req("b2b_a", 1'b1, 1'b1);
    step(1'b1, 32'h0000_0014, 1'b0, 6'd0, 1'b1, 1'b0, 32'h0);
    chk_req("b2b_b", 1'b1, 1'b1);
    step(1'b1, 32'h0000_0018, 1'b0, 6'd0, 1'b1, 1'b0, 32'h0);
    chk_req("b2b_c_full", 1'b0, 1'b0);
    // response frees a slot, but not in this cycle
    step(1'b1, 32'h0000_0018, 1'b0, 6'd0, 1'b1, 1'b1, 32'h0000_000A);
    chk_req("b2b_c_stall", 1'b0, 1'b0);
    chk_rsp("b2b_rsp_a", 1'b1, 1'b0, 32'h0000_000A);
    step(1'b1, 32'h0000_0018, 1'b0, 6'd0, 1'b1, 1'b1, 32'h0000_000B);
    chk_req("b2b_c_gnt", 1'b1, 1'b1);
    chk_rsp("b2b_rsp_b", 1'b1, 1'b0, 32'h0000_000B);
    step(1'b0, 32'h0, 1'b0, 6'd0, 1'b0, 1'b1, 32'h0000_000C);
    chk_rsp("b2b_rsp_c", 1'b1, 1'b0, 32'h0000_000C);
    // counter back at zero: stray response ignored
    step(1'b0, 32'h0, 1'b0, 6'd0, 1'b0, 1'b1, 32'h5555_5555);
    chk_rsp("stray", 1'b0, 1'b0, 32'h0);

    // out-of-window write with nothing in flight
    step(1'b1, 32'h0020_0000, 1'b1, 6'd0, 1'b1, 1'b0, 32'h0);
    chk_req("oow", 1'b1, 1'b0);
    // error response; a new legal request is held off this cycle
    step(1'b1, 32'h0000_0100, 1'b0, 6'd0, 1'b1, 1'b0, 32'h0);
    chk_rsp("oow_rsp", 1'b1, 1'b1, 32'h0);
    chk_req("oow_block", 1'b0, 1'b0);
    step(1'b1, 32'h0000_0100, 1'b0, 6'd0, 1'b1, 1'b0, 32'h0);
    chk_req("after_err", 1'b1, 1'b1);
    chk_rsp("after_err", 1'b0, 1'b0, 32'h0);

    // illegal request while one read is outstanding
    step(1'b1, 32'h0030_0000, 1'b0, 6'd0, 1'b1, 1'b0, 32'h0);
    chk_req("ill_busy", 1'b0, 1'b0);
    step(1'b1, 32'h0030_0000, 1'b0, 6'd0, 1'b1, 1'b1, 32'h0000_0077);
    chk_req("ill_busy_rsp", 1'b0, 1'b0);
    chk_rsp("ill_busy_rsp", 1'b1, 1'b0, 32'h0000_0077);
    step(1'b1, 32'h0030_0000, 1'b0, 6'd0, 1'b1, 1'b0, 32'h0);
    chk_req("ill_gnt", 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0);
    chk_rsp("ill_err", 1'b1, 1'b1, 32'h0);
    step(1'b0, 32'h0, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0);
    chk_rsp("ill_done", 1'b0, 1'b0, 32'h0);

    // atomic on a legal address
    step(1'b1, 32'h0000_0100, 1'b0, 6'h02, 1'b1, 1'b0, 32'h0);
    chk_req("atop", 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0);
    chk_rsp("atop_err", 1'b1, 1'b1, 32'h0);

    // window boundaries: last word inside (TCDM stalls), first byte outside
    step(1'b1, 32'h000F_FFFC, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0);
    chk_req("win_top", 1'b0, 1'b1);
    step(1'b1, 32'h0010_0000, 1'b0, 6'd0, 1'b1, 1'b0, 32'h0);
    chk_req("win_end", 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0);
    chk_rsp("win_end_err", 1'b1, 1'b1, 32'h0);

    // misaligned read
`ifdef BRIDGE_MISALIGN_CHK_EN
    step(1'b1, 32'h0000_0102, 1'b0, 6'd0, 1'b1, 1'b0, 32'h0);
    chk_req("mis", 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0);
    chk_rsp("mis_err", 1'b1, 1'b1, 32'h0);
`else
    step(1'b1, 32'h0000_0102, 1'b0, 6'd0, 1'b1, 1'b0, 32'h0);
    chk_req("mis", 1'b1, 1'b1);
    chk("mis_add", tcdm_add, 32'h0000_0100);
    step(1'b0, 32'h0, 1'b0, 6'd0, 1'b0, 1'b1, 32'hCAFE_F00D);
    chk_rsp("mis_rsp", 1'b1, 1'b0, 32'hCAFE_F00D);
`endif

    // reset with two reads in flight
    step(1'b1, 32'h0000_0040, 1'b0, 6'd0, 1'b1, 1'b0, 32'h0);
    chk_req("pre_rst_a", 1'b1, 1'b1);
    step(1'b1, 32'h0000_0044, 1'b0, 6'd0, 1'b1, 1'b0, 32'h0);
    chk_req("pre_rst_b", 1'b1, 1'b1);
    step(1'b1, 32'h0000_0048, 1'b0, 6'd0, 1'b1, 1'b1, 32'h1111_1111);
    rst = 1'b1;
    #1;
    chk_req("mid_rst", 1'b0, 1'b0);
    chk_rsp("mid_rst", 1'b0, 1'b0, 32'h0);
    chk("mid_rst_exokay", {31'd0, core_exokay}, 32'd0);
    step(1'b0, 32'h0, 1'b0, 6'd0, 1'b0, 1'b1, 32'h2222_2222);
    rst = 1'b0;
    #1;
    chk_rsp("late_rsp", 1'b0, 1'b0, 32'h0);
    // counter restarted from zero: two slots available again
    step(1'b1, 32'h0000_0050, 1'b0, 6'd0, 1'b1, 1'b0, 32'h0);
    chk_req("post_rst_a", 1'b1, 1'b1);
    step(1'b1, 32'h0000_0054, 1'b0, 6'd0, 1'b1, 1'b0, 32'h0);
    chk_req("post_rst_b", 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b0, 6'd0, 1'b0, 1'b1, 32'h3333_3333);
    chk_rsp("post_rst_rsp", 1'b1, 1'b0, 32'h3333_3333);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
